// File: rtl/packet_pkg.sv
// Shared definitions for the option-packet byte assembler and the downstream packet register.
package packet_pkg;

    localparam int unsigned DATASIZE  = 224;
    localparam int unsigned NBYTES    = DATASIZE / 8;
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2,
        ISSUE   = 2'd3
    } asm_state_t;

    // Field positions inside the packet, most significant field first
    localparam int unsigned SPTPRICE_MSB   = 223;
    localparam int unsigned SPTPRICE_LSB   = 192;
    localparam int unsigned STRIKE_MSB     = 191;
    localparam int unsigned STRIKE_LSB     = 160;
    localparam int unsigned RATE_MSB       = 159;
    localparam int unsigned RATE_LSB       = 128;
    localparam int unsigned VOLATILITY_MSB = 127;
    localparam int unsigned VOLATILITY_LSB = 96;
    localparam int unsigned TIME_R_MSB     = 95;
    localparam int unsigned TIME_R_LSB     = 64;
    localparam int unsigned OTYPE_MSB      = 63;
    localparam int unsigned OTYPE_LSB      = 32;
    localparam int unsigned TIMET_MSB      = 31;
    localparam int unsigned TIMET_LSB      = 0;

    typedef struct packed {
        logic [31:0] sptprice;
        logic [31:0] strike;
        logic [31:0] rate;
        logic [31:0] volatility;
        logic [31:0] time_r;
        logic [31:0] otype;
        logic [31:0] timet;
    } option_pkt_t;

endpackage

// File: rtl/packet_assembler_timer.sv
// byte_timeout_timer: saturating idle-clock counter; expired flags TIMEOUT_CYCLES-1 clocks without a clear.
module byte_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    // Saturate at LAST so a long silence never wraps back to a non-expired value
    always_comb begin
        count_next = count;
        if (clear)
            count_next = '0;
        else if (count != LAST)
            count_next = count + CW'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count   <= '0;
            expired <= 1'b0;
        end else begin
            count   <= count_next;
            expired <= (count_next == LAST);
        end
    end

endmodule

// File: rtl/packet_assembler.sv
// Frames SYNC_BYTE-delimited byte stream into one DATASIZE-bit packet and hands it downstream.
// Optional trailing XOR checksum byte enabled by defining PKT_CHECKSUM_EN.
module packet_assembler #(
    parameter int unsigned DATASIZE       = packet_pkg::DATASIZE,
    parameter logic [7:0]  SYNC_BYTE      = packet_pkg::SYNC_BYTE,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                byte_valid,
    input  logic [7:0]          byte_in,
    input  logic                hasUnusedData,
    output logic [DATASIZE-1:0] outD,
    output logic                en,
    output logic                busy,
    output logic                error,
    output logic                overrun
);

    localparam int unsigned NBYTES = DATASIZE / 8;
    localparam int unsigned CNT_W  = $clog2(NBYTES + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

    localparam logic [1:0] ST_IDLE    = 2'(packet_pkg::IDLE);
    localparam logic [1:0] ST_COLLECT = 2'(packet_pkg::COLLECT);
    localparam logic [1:0] ST_HOLD    = 2'(packet_pkg::HOLD);
    localparam logic [1:0] ST_ISSUE   = 2'(packet_pkg::ISSUE);

`ifdef PKT_CHECKSUM_EN
    // Full-width store: the packet is complete before the checksum byte arrives
    localparam int unsigned SR_W = DATASIZE;
    localparam logic [CNT_W-1:0] CHK_IDX = CNT_W'(NBYTES);
    logic [7:0] chk, chk_next;
`else
    localparam int unsigned SR_W = DATASIZE - 8;
`endif

    logic [1:0]          state, state_next;
    logic [SR_W-1:0]     sr, sr_next;
    logic [DATASIZE-1:0] shifted;
    logic [DATASIZE-1:0] outd_next;
    logic [CNT_W-1:0]    count, count_next;
    logic                en_next, error_next, overrun_next, busy_next;
    logic                timer_clear, timer_expired;

`ifdef PKT_CHECKSUM_EN
    assign shifted = {sr[DATASIZE-9:0], byte_in};
`else
    assign shifted = {sr, byte_in};
`endif

    // Timer only runs while collecting; any accepted byte restarts it
    assign timer_clear = (state != ST_COLLECT) || byte_valid;

    byte_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (timer_clear),
        .expired (timer_expired)
    );

    always_comb begin
        state_next   = state;
        sr_next      = sr;
        count_next   = count;
        outd_next    = outD;
        en_next      = 1'b0;
        error_next   = 1'b0;
        overrun_next = 1'b0;
`ifdef PKT_CHECKSUM_EN
        chk_next     = chk;
`endif
        case (state)
            ST_IDLE: begin
                if (byte_valid && byte_in == SYNC_BYTE) begin
                    state_next = ST_COLLECT;
                    count_next = '0;
`ifdef PKT_CHECKSUM_EN
                    chk_next   = '0;
`endif
                end
            end
            ST_COLLECT: begin
                // A byte arriving on the expiry cycle takes priority over the timeout
                if (byte_valid) begin
`ifdef PKT_CHECKSUM_EN
                    if (count == CHK_IDX) begin
                        if (byte_in == chk) begin
                            outd_next  = sr;
                            state_next = ST_HOLD;
                        end else begin
                            error_next = 1'b1;
                            state_next = ST_IDLE;
                        end
                    end else begin
                        sr_next    = shifted;
                        count_next = count + CNT_W'(1);
                        chk_next   = chk ^ byte_in;
                    end
`else
                    sr_next    = shifted[SR_W-1:0];
                    count_next = count + CNT_W'(1);
                    if (count == LAST_IDX) begin
                        outd_next  = shifted;
                        state_next = ST_HOLD;
                    end
`endif
                end else if (timer_expired) begin
                    error_next = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_HOLD: begin
                overrun_next = byte_valid;
                if (!hasUnusedData) begin
                    state_next = ST_ISSUE;
                    en_next    = 1'b1;
                end
            end
            ST_ISSUE: begin
                overrun_next = byte_valid;
                state_next   = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            sr      <= '0;
            count   <= '0;
            outD    <= '0;
            en      <= 1'b0;
            busy    <= 1'b0;
            error   <= 1'b0;
            overrun <= 1'b0;
`ifdef PKT_CHECKSUM_EN
            chk     <= '0;
`endif
        end else begin
            state   <= state_next;
            sr      <= sr_next;
            count   <= count_next;
            outD    <= outd_next;
            en      <= en_next;
            busy    <= busy_next;
            error   <= error_next;
            overrun <= overrun_next;
`ifdef PKT_CHECKSUM_EN
            chk     <= chk_next;
`endif
        end
    end

endmodule

// File: tb/tb_packet_assembler.sv
// Scoreboard bench for packet_assembler: stimulus queues expected en/error/overrun events, a monitor checks them.
module tb_packet_assembler;
    import packet_pkg::*;

    localparam int unsigned TO = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         byte_valid = 1'b0;
    logic [7:0]   byte_in = 8'h00;
    logic         hasUnusedData = 1'b0;
    logic [223:0] outD;
    logic         en, busy, error, overrun;

    packet_assembler #(
        .DATASIZE       (224),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .byte_valid    (byte_valid),
        .byte_in       (byte_in),
        .hasUnusedData (hasUnusedData),
        .outD          (outD),
        .en            (en),
        .busy          (busy),
        .error         (error),
        .overrun       (overrun)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [223:0] data;
        int           cyc;
    } exp_t;

    exp_t en_q[$];
    exp_t err_q[$];
    exp_t ovr_q[$];

    logic [7:0] pay [28];

    task automatic check(input string name, input logic [223:0] act, input logic [223:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, need %h", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, need %0d", name, act, req);
        end
    endtask

    // Monitor: every strobe must match the oldest pending expectation of its kind
    always @(negedge clock) begin
        exp_t e;
        if (en === 1'b1) begin
            if (en_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL en_unexpected: got en=1 at cycle %0d, need no strobe", cyc);
            end else begin
                e = en_q.pop_front();
                check("en_data", outD, e.data);
                check_int("en_cycle", cyc, e.cyc);
            end
        end
        if (error === 1'b1) begin
            if (err_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL error_unexpected: got error=1 at cycle %0d, need no pulse", cyc);
            end else begin
                e = err_q.pop_front();
                check_int("error_cycle", cyc, e.cyc);
            end
        end
        if (overrun === 1'b1) begin
            if (ovr_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL overrun_unexpected: got overrun=1 at cycle %0d, need no pulse", cyc);
            end else begin
                e = ovr_q.pop_front();
                check_int("overrun_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic expect_en(input logic [223:0] d, input int c);
        exp_t e;
        e.data = d; e.cyc = c;
        en_q.push_back(e);
    endtask

    task automatic expect_err(input int c);
        exp_t e;
        e.data = '0; e.cyc = c;
        err_q.push_back(e);
    endtask

    task automatic expect_ovr(input int c);
        exp_t e;
        e.data = '0; e.cyc = c;
        ovr_q.push_back(e);
    endtask

    // Drive for one cycle; returns 1ns after the sampling edge with cyc = that edge's index
    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_in    = b;
        @(posedge clock);
        #1;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic logic [223:0] pack_pay();
        logic [223:0] r;
        r = '0;
        for (int i = 0; i < 28; i++) r[223 - 8*i -: 8] = pay[i];
        return r;
    endfunction

    function automatic logic [7:0] xor_pay();
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 28; i++) x = x ^ pay[i];
        return x;
    endfunction

    task automatic send_payload();
        send_byte(8'hA5);
        for (int i = 0; i < 28; i++) send_byte(pay[i]);
    endtask

    // Full frame; last_edge is the edge that accepted the final byte of the frame
    task automatic send_frame(output int last_edge);
        send_payload();
`ifdef PKT_CHECKSUM_EN
        send_byte(xor_pay());
`endif
        last_edge = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 time units, need completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int le;
        logic [223:0] p1, p3, p4, p5;

        idle(3);
        reset = 1'b0;
        check("reset_outD", outD, '0);
        check("reset_en", 224'(en), 224'(0));
        check("reset_busy", 224'(busy), 224'(0));
        check("reset_error", 224'(error), 224'(0));
        check("reset_overrun", 224'(overrun), 224'(0));

        // Basic frame, downstream free
        for (int i = 0; i < 28; i++) pay[i] = 8'(i + 1);
        p1 = pack_pay();
        send_frame(le);
        expect_en(p1, le + 1);
        idle(4);
        check("t1_outD", outD, p1);
        check("t1_first_byte", 224'(outD[223:216]), 224'(8'h01));
        check("t1_last_byte", 224'(outD[7:0]), 224'(8'h1C));
        check("t1_busy_after", 224'(busy), 224'(0));

        // Downstream busy for 50 cycles, then released
        hasUnusedData = 1'b1;
        send_frame(le);
        idle(50);
        check("t2_busy_hold", 224'(busy), 224'(1));
        check("t2_outD_hold", outD, p1);
        hasUnusedData = 1'b0;
        expect_en(p1, cyc + 1);
        idle(4);
        check("t2_busy_after", 224'(busy), 224'(0));

        // Partial frame then silence
        send_byte(8'hA5);
        for (int i = 0; i < 5; i++) send_byte(8'(8'h11 + i));
        le = cyc;
        expect_err(le + int'(TO));
        idle(int'(TO) + 4);
        check("t3_outD_kept", outD, p1);
        check("t3_busy", 224'(busy), 224'(0));
        for (int i = 0; i < 28; i++) pay[i] = 8'(8'h80 + i);
        p3 = pack_pay();
        send_frame(le);
        expect_en(p3, le + 1);
        idle(4);
        check("t3_next_frame", outD, p3);

        // Garbage before sync, sync value inside payload
        send_byte(8'h00);
        send_byte(8'h3C);
        for (int i = 0; i < 28; i++) pay[i] = 8'(i + 1);
        pay[2] = 8'hA5;
        p4 = pack_pay();
        send_frame(le);
        expect_en(p4, le + 1);
        idle(4);
        check("t4_sync_in_payload", 224'(outD[207:200]), 224'(8'hA5));

        // Bytes dropped in HOLD and ISSUE
        hasUnusedData = 1'b1;
        for (int i = 0; i < 28; i++) pay[i] = 8'(8'h40 + i);
        p5 = pack_pay();
        send_frame(le);
        send_byte(8'h5A);
        expect_ovr(cyc);
        send_byte(8'hA5);
        expect_ovr(cyc);
        idle(3);
        hasUnusedData = 1'b0;
        expect_en(p5, cyc + 1);
        idle(1);
        send_byte(8'h77);
        expect_ovr(cyc);
        idle(3);
        check("t5_outD", outD, p5);

        // Reset lands on byte 10 of the next frame
        send_byte(8'hA5);
        for (int i = 0; i < 9; i++) send_byte(8'(8'h60 + i));
        reset = 1'b1;
        send_byte(8'h69);
        reset = 1'b0;
        check("t5_reset_outD", outD, '0);
        check("t5_reset_en", 224'(en), 224'(0));
        check("t5_reset_busy", 224'(busy), 224'(0));
        idle(int'(TO) + 10);
        check("t5_idle_after_reset", 224'(busy), 224'(0));

`ifdef PKT_CHECKSUM_EN
        for (int i = 0; i < 28; i++) pay[i] = 8'(i + 1);
        check("chk_xor_value", 224'(xor_pay()), 224'(8'h1C));
        send_payload();
        send_byte(8'h1C);
        expect_en(p1, cyc + 1);
        idle(4);
        check("chk_good_outD", outD, p1);
        for (int i = 0; i < 28; i++) pay[i] = 8'(8'h80 + i);
        send_payload();
        send_byte(8'h00);
        expect_err(cyc);
        idle(5);
        check("chk_bad_outD", outD, p1);
        check("chk_bad_busy", 224'(busy), 224'(0));
`endif

        idle(5);
        check_int("en_q_drained", en_q.size(), 0);
        check_int("err_q_drained", err_q.size(), 0);
        check_int("ovr_q_drained", ovr_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
